// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and size helper for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Access size in bytes; funct3[1:0] carries the width for both loads and stores
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane shifting of store data/enables and load merge/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [7:0]  o_wide_mask,
  output logic [63:0] o_wide_data,
  output logic [31:0] o_load_data
);

  logic [3:0]  w_size_mask;
  logic [31:0] w_shifted;

  // Two-word lane view: low half drives the first access, high half the second
  always_comb begin
    w_size_mask = 4'b1111;
    case (size_of(i_funct3))
      3'd1:    w_size_mask = 4'b0001;
      3'd2:    w_size_mask = 4'b0011;
      default: w_size_mask = 4'b1111;
    endcase
    o_wide_mask = {4'b0000, w_size_mask} << i_offset;
    o_wide_data = {32'h0, i_wdata} << {i_offset, 3'b000};
  end

  // Pull the addressed bytes down to bit 0, then truncate and extend by funct3
  always_comb begin
    w_shifted   = 32'({i_hi, i_lo} >> {i_offset, 3'b000});
    o_load_data = w_shifted;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_load_data = {24'h0, w_shifted[7:0]};
      F3_HU:   o_load_data = {16'h0, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit with misaligned split and valid/ready response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_BYTES        = 4096,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  lsu_state_t            r_state;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cross;
  logic [DATA_WIDTH-1:0] r_lo;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  logic [2:0]            w_size;
  logic                  w_cross;
  logic                  w_illegal;
  logic                  w_oob;
  logic                  w_fault;
  logic [7:0]            w_wide_mask;
  logic [63:0]           w_wide_data;
  logic [31:0]           w_load_data;
  logic [31:0]           w_lo;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  // Decode the incoming request so a fault can skip memory entirely
  always_comb begin
    w_size    = size_of(req_funct3);
    w_cross   = ({1'b0, req_addr[1:0]} + w_size) > 3'd4;
    w_illegal = req_store ? (req_funct3 >= 3'b011)
                          : (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                             req_funct3 == 3'b111);
    w_oob     = ({1'b0, req_addr} + (ADDR_WIDTH+1)'(w_size)) >
                (ADDR_WIDTH+1)'(MEM_BYTES);
    w_fault   = w_illegal || w_oob || (w_cross && !ALLOW_MISALIGNED);
  end

  // In ACC1 the low word is still on the bus; in ACC2 it comes from r_lo
  assign w_lo        = (r_state == ACC1) ? mem_rdata : r_lo;
  assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

  lsu_align u_align (
    .i_funct3    (r_funct3),
    .i_offset    (r_addr[1:0]),
    .i_wdata     (r_wdata),
    .i_hi        (mem_rdata),
    .i_lo        (w_lo),
    .o_wide_mask (w_wide_mask),
    .o_wide_data (w_wide_data),
    .o_load_data (w_load_data)
  );

  // Memory port is only live during the access states; reset kills any write
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    mem_we    = 1'b0;
    case (r_state)
      ACC1: begin
        mem_addr  = w_word_addr;
        mem_wdata = w_wide_data[31:0];
        mem_be    = w_wide_mask[3:0];
        mem_we    = r_store && !rst;
      end
      ACC2: begin
        mem_addr  = w_word_addr + ADDR_WIDTH'(4);
        mem_wdata = w_wide_data[63:32];
        mem_be    = w_wide_mask[7:4];
        mem_we    = r_store && !rst;
      end
      default: ;
    endcase
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // Request sequencing: accept, one or two word accesses, hold response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_store      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cross      <= 1'b0;
      r_lo         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cross  <= w_cross;
            if (w_fault) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state <= ACC1;
            end
          end
        end
        ACC1: begin
          r_lo <= mem_rdata;
          if (r_cross) begin
            r_state <= ACC2;
          end else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_store ? '0 : w_load_data;
          end
        end
        ACC2: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_store ? '0 : w_load_data;
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-lane memory model
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          we_cnt = 0;
  logic [31:0] s_addr  [1:3];
  logic [31:0] s_wdata [1:3];
  logic [3:0]  s_be    [1:3];
  logic        s_we    [1:3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
  end

  // Response monitor: pops the oldest expectation whenever a response is taken
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got rdata 0x%0h err %0b, expected none", resp_rdata, resp_err);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_rdata", {32'h0, resp_rdata}, {32'h0, mon_e.rdata});
        check("resp_err", {63'h0, resp_err}, {63'h0, mon_e.err});
      end
    end
  end

  task automatic snap(input int k);
    if (k >= 1 && k <= 3) begin
      s_addr[k]  = mem_addr;
      s_wdata[k] = mem_wdata;
      s_be[k]    = mem_be;
      s_we[k]    = mem_we;
    end
  endtask

  // Issue one request at a negedge; returns at the negedge where resp_valid is seen,
  // or one cycle later (DUT idle again) when resp_ready is high
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int elat, input string name);
    int lat;
    check({name, "_req_ready"}, {63'h0, req_ready}, 64'h1);
    sb_q.push_back('{rdata: er, err: ee});
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    snap(lat);
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      snap(lat);
    end
    check({name, "_latency"}, 64'(lat), 64'(elat));
    if (resp_ready) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("rst_resp_rdata", {32'h0, resp_rdata}, 64'h0);
    check("rst_resp_err", {63'h0, resp_err}, 64'h0);
    check("rst_req_ready", {63'h0, req_ready}, 64'h1);
    check("rst_mem_we", {63'h0, mem_we}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned word store and reload
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw10");
    check("sw10_addr", {32'h0, s_addr[1]}, 64'h10);
    check("sw10_be", {60'h0, s_be[1]}, 64'hF);
    check("sw10_we", {63'h0, s_we[1]}, 64'h1);
    check("sw10_wdata", {32'h0, s_wdata[1]}, 64'hDEADBEEF);
    do_req(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw10");

    // Single byte into lane 3, then signed/unsigned byte and half reads
    do_req(1'b1, F3_B, 32'h13, 32'h80, 32'h0, 1'b0, 2, "sb13");
    check("sb13_addr", {32'h0, s_addr[1]}, 64'h10);
    check("sb13_be", {60'h0, s_be[1]}, 64'h8);
    check("sb13_wdata", {32'h0, s_wdata[1]}, 64'h80000000);
    do_req(1'b0, F3_B, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, "lb13");
    do_req(1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, "lbu13");
    do_req(1'b0, F3_HU, 32'h12, 32'h0, 32'h000080AD, 1'b0, 2, "lhu12");
    do_req(1'b0, F3_H, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 2, "lh12");

    // Word store crossing into the next word
    do_req(1'b1, F3_W, 32'h22, 32'h11223344, 32'h0, 1'b0, 3, "sw22");
    check("sw22_a1_addr", {32'h0, s_addr[1]}, 64'h20);
    check("sw22_a1_be", {60'h0, s_be[1]}, 64'hC);
    check("sw22_a1_wdata", {32'h0, s_wdata[1]}, 64'h33440000);
    check("sw22_a2_addr", {32'h0, s_addr[2]}, 64'h24);
    check("sw22_a2_be", {60'h0, s_be[2]}, 64'h3);
    check("sw22_a2_wdata", {32'h0, s_wdata[2]}, 64'h00001122);
    check("sw22_a2_we", {63'h0, s_we[2]}, 64'h1);
    do_req(1'b0, F3_W, 32'h22, 32'h0, 32'h11223344, 1'b0, 3, "lw22");
    do_req(1'b0, F3_H, 32'h23, 32'h0, 32'h00002233, 1'b0, 3, "lh23");

    // Faults never touch memory; last byte of memory is still legal
    we_cnt = 0;
    do_req(1'b0, F3_W, 32'hFFE, 32'h0, 32'h0, 1'b1, 1, "lw_ffe");
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, "ld_f3_011");
    do_req(1'b1, 3'b011, 32'h10, 32'h12345678, 32'h0, 1'b1, 1, "st_f3_011");
    check("fault_no_write", 64'(we_cnt), 64'h0);
    do_req(1'b0, F3_B, 32'hFFF, 32'h0, 32'h0, 1'b0, 2, "lb_fff");

    // Back-pressure: response and data held, no new request accepted
    resp_ready = 1'b0;
    do_req(1'b0, F3_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 2, "hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {63'h0, resp_valid}, 64'h1);
      check("hold_rdata", {32'h0, resp_rdata}, 64'h80ADBEEF);
      check("hold_req_ready", {63'h0, req_ready}, 64'h0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_valid", {63'h0, resp_valid}, 64'h0);
    check("release_req_ready", {63'h0, req_ready}, 64'h1);

    // Reset during the first access of a crossing store
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h22;
    req_wdata  = 32'hAABBCCDD;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_acc1_we", {63'h0, mem_we}, 64'h0);
    @(negedge clk);
    check("rst2_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("rst2_resp_rdata", {32'h0, resp_rdata}, 64'h0);
    check("rst2_resp_err", {63'h0, resp_err}, 64'h0);
    check("rst2_req_ready", {63'h0, req_ready}, 64'h1);
    check("rst2_mem_be", {60'h0, mem_be}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, F3_W, 32'h20, 32'h0, 32'h33440000, 1'b0, 2, "lw20_old");
    do_req(1'b0, F3_W, 32'h24, 32'h0, 32'h00001122, 1'b0, 2, "lw24_old");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
